wb_line_arbiter: RTL and testbench
==================================

// Module: wb_line_arbiter
// PURPOSE
//   Two-master, one-slave Wishbone arbiter for 128-bit cache-line traffic.
//   Sits directly downstream of the instruction and data caches' memory-side
//   masters. Merges them onto the single physical-memory/L2 Wishbone port.
//   Grants one master per line transaction, round-robin, with a one-cycle
//   idle gap between grants.
// PARAMETERS
//   ADDR_W  12   line address width (byte address [15:4])
//   DATA_W  128  line data width
//   SEL_W   16   byte-select width (DATA_W/8)
// PORTS
//   clk                  in   1       system clock; all state updates on rising edge
//   rst_n                in   1       reset, asynchronous, active-low
//   m0_cyc,m0_stb,m0_we  in   1 each  master 0 (I-cache) bus cycle, strobe, write
//   m0_adr               in   ADDR_W  master 0 line address
//   m0_dat_m             in   DATA_W  master 0 write data
//   m0_sel               in   SEL_W   master 0 byte selects
//   m0_ack               out  1       ack to master 0
//   m0_dat_s             out  DATA_W  read data to master 0
//   m1_*                 (same set)   master 1 (D-cache)
//   s_cyc,s_stb,s_we     out  1 each  to memory slave
//   s_adr                out  ADDR_W
//   s_dat_m              out  DATA_W
//   s_sel                out  SEL_W
//   s_ack                in   1       ack from memory
//   s_dat_s              in   DATA_W  read data from memory
// BEHAVIOUR
//   - Request: mN_req = mN_cyc & mN_stb.
//   - FSM state_q in {IDLE, GNT0, GNT1}; also a last_q flag (last granted master).
//   - Reset (async, rst_n=0): state_q=IDLE, last_q=1, so master 0 wins the first tie.
//   - IDLE transitions:
//     - m0_req only -> GNT0.
//     - m1_req only -> GNT1.
//     - both -> grant the master != last_q.
//     - none -> stay.
//   - Grant timing: the grant is registered.
//     - s_stb asserts the cycle after the request is first seen in IDLE.
//     - Minimum request-to-s_stb latency is 1 cycle.
//   - In GNTn: s_cyc/s_stb/s_we/s_adr/s_dat_m/s_sel = mN_* (combinational).
//     - mN_ack = s_ack; the other master's ack is 0.
//     - mN_dat_s = s_dat_s; the other master's dat_s is 0.
//     - last_q <= n on entry.
//   - GNTn -> IDLE when s_ack=1 (end of line transfer).
//     - The IDLE cycle drives s_cyc=s_stb=0, guaranteeing a deasserted strobe between transactions.
//   - GNTn -> IDLE when mN_cyc drops before s_ack (abort).
//     - s_ack arriving in that same cycle is still routed to mN.
//   - In IDLE all outputs are 0: s_*, m*_ack, m*_dat_s. This is also the reset value of every output.
//   - s_ack while IDLE is ignored and not forwarded.
//   - A losing master holds its request. It is granted on the next IDLE cycle because of round-robin; there is no starvation.
//   - The granted master's fields may change mid-grant; they are forwarded unlatched.
//   - Reset asserted mid-transaction: outputs drop to 0 asynchronously and the memory-side cycle is abandoned.
// STRUCTURE
//   - lc3b_types gains:
//     - typedef enum logic [1:0] {ARB_IDLE, ARB_GNT0, ARB_GNT1} arb_state_t;
//     - constants LINE_ADDR_W=12, LINE_DATA_W=128, LINE_SEL_W=16.
//   - One sub-module: wb_rr_pick.
//     - Combinational 2-way round-robin picker.
//     - Inputs: req[1:0], last. Outputs: valid, pick.
//   - The FSM, registers and mux live in the top level.
// TESTING
//   1. Reset with rst_n=0 while both masters request.
//      -> All outputs 0.
//      -> Release reset: GNT0 is reached 1 cycle later (last_q=1); s_adr=m0_adr.
//   2. m1 read alone, adr=12'h0A5.
//      -> Cycle+1: s_stb=1, s_we=0, s_adr=12'h0A5.
//      -> Memory acks with s_dat_s=128'hDEAD..BEEF: m1_ack=1, m1_dat_s matches, m0_ack=0.
//      -> Next cycle: s_stb=0.
//   3. Both request continuously.
//      -> Grants alternate m0,m1,m0,m1.
//      -> Each grant is separated by exactly one IDLE cycle with s_cyc=0.
//   4. m0 write, sel=16'hFFFF, dat=128'h0123_..._CDEF.
//      -> s_we=1 and s_dat_m/s_sel match through grant.
//      -> Stray s_ack while IDLE -> m0_ack=m1_ack=0.
//   5. m1 granted, then drops cyc before s_ack.
//      -> IDLE the next cycle.
//      -> A pending m0 is granted in the following cycle.
//   6. rst_n pulsed low mid-GNT0 (asynchronously, between edges).
//      -> s_stb falls immediately without waiting for clk.
//      -> After release, state is IDLE and last_q=1.

Source files
------------

// File: rtl/wb_line_arbiter_pkg.sv
// Shared types and line-bus widths for the two-master cache-line Wishbone arbiter.
package wb_line_arbiter_pkg;

    localparam int LINE_ADDR_W = 12;
    localparam int LINE_DATA_W = 128;
    localparam int LINE_SEL_W  = 16;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GNT0, ARB_GNT1} arb_state_t;

endpackage

// File: rtl/wb_line_arbiter_if.sv
// One cache-line Wishbone link; master drives the cycle, slave returns ack/data.
interface wb_line_arbiter_if
    import wb_line_arbiter_pkg::*;
#(
    parameter int ADDR_W = LINE_ADDR_W,
    parameter int DATA_W = LINE_DATA_W,
    parameter int SEL_W  = LINE_SEL_W
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat_m;
    logic [SEL_W-1:0]  sel;
    logic              ack;
    logic [DATA_W-1:0] dat_s;

    modport master (output cyc, stb, we, adr, dat_m, sel, input  ack, dat_s);
    modport slave  (input  cyc, stb, we, adr, dat_m, sel, output ack, dat_s);
endinterface

// File: rtl/wb_line_arbiter_rr_pick.sv
// Two-way round-robin picker: on a tie the master that was not granted last wins.
module wb_rr_pick (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_pick
);
    assign o_valid = |i_req;
    assign o_pick  = (&i_req) ? ~i_last : i_req[1];
endmodule

// File: rtl/wb_line_arbiter.sv
// Merges I-cache (m0) and D-cache (m1) line masters onto one memory port,
// one line transaction per grant with an idle cycle between grants.
module wb_line_arbiter
    import wb_line_arbiter_pkg::*;
#(
    parameter int ADDR_W = LINE_ADDR_W,
    parameter int DATA_W = LINE_DATA_W,
    parameter int SEL_W  = LINE_SEL_W
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_line_arbiter_if.slave  m0,
    wb_line_arbiter_if.slave  m1,
    wb_line_arbiter_if.master s
);
    arb_state_t        r_state, w_state_nxt;
    logic              r_last, w_last_nxt;
    logic [1:0]        w_req;
    logic              w_pick_vld, w_pick;
    logic [ADDR_W-1:0] w_adr;
    logic [DATA_W-1:0] w_dat_m, w_dat_s;
    logic [SEL_W-1:0]  w_sel;

    assign w_req   = {m1.cyc & m1.stb, m0.cyc & m0.stb};
    assign w_dat_s = s.dat_s;

    wb_rr_pick u_pick (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_valid (w_pick_vld),
        .o_pick  (w_pick)
    );

    // r_last resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // A grant ends on the memory ack or when the owner drops cyc (abort).
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            ARB_IDLE: if (w_pick_vld) begin
                w_state_nxt = w_pick ? ARB_GNT1 : ARB_GNT0;
                w_last_nxt  = w_pick;
            end
            ARB_GNT0: if (s.ack || !m0.cyc) w_state_nxt = ARB_IDLE;
            ARB_GNT1: if (s.ack || !m1.cyc) w_state_nxt = ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
    end

    // Granted master's fields pass through unlatched; idle drives everything to 0.
    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        w_adr    = '0;
        w_dat_m  = '0;
        w_sel    = '0;
        m0.ack   = 1'b0;
        m0.dat_s = '0;
        m1.ack   = 1'b0;
        m1.dat_s = '0;
        case (r_state)
            ARB_GNT0: begin
                s.cyc    = m0.cyc;
                s.stb    = m0.stb;
                s.we     = m0.we;
                w_adr    = m0.adr;
                w_dat_m  = m0.dat_m;
                w_sel    = m0.sel;
                m0.ack   = s.ack;
                m0.dat_s = w_dat_s;
            end
            ARB_GNT1: begin
                s.cyc    = m1.cyc;
                s.stb    = m1.stb;
                s.we     = m1.we;
                w_adr    = m1.adr;
                w_dat_m  = m1.dat_m;
                w_sel    = m1.sel;
                m1.ack   = s.ack;
                m1.dat_s = w_dat_s;
            end
            default: ;
        endcase
        s.adr   = w_adr;
        s.dat_m = w_dat_m;
        s.sel   = w_sel;
    end
endmodule

// File: tb/tb_wb_line_arbiter.sv
// Directed bench for wb_line_arbiter: reset, single reads, round-robin, writes, abort, async reset.
module tb_wb_line_arbiter;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    localparam logic [127:0] D_RST  = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    localparam logic [127:0] D_ONE  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] D_BEEF = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [127:0] D_WR   = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

    wb_line_arbiter_if m0_if ();
    wb_line_arbiter_if m1_if ();
    wb_line_arbiter_if s_if ();

    wb_line_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        // 1. reset with both masters requesting and a live s_ack
        rst_n = 1'b0;
        m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b0;
        m0_if.adr = 12'h111; m0_if.dat_m = '0; m0_if.sel = 16'h0000;
        m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.we = 1'b0;
        m1_if.adr = 12'h222; m1_if.dat_m = '0; m1_if.sel = 16'h0000;
        s_if.ack = 1'b1; s_if.dat_s = D_RST;
        #2;
        chk("rst_s_cyc", s_if.cyc, 0);
        chk("rst_s_stb", s_if.stb, 0);
        chk("rst_s_adr", s_if.adr, 0);
        chk("rst_m0_ack", m0_if.ack, 0);
        chk("rst_m1_ack", m1_if.ack, 0);
        chk("rst_m0_dat_s", m0_if.dat_s, 0);
        nxt();
        nxt();
        rst_n = 1'b1; s_if.ack = 1'b0;
        settle();
        chk("post_rst_idle_stb", s_if.stb, 0);
        nxt();
        chk("first_gnt0_stb", s_if.stb, 1);
        chk("first_gnt0_cyc", s_if.cyc, 1);
        chk("first_gnt0_adr", s_if.adr, 12'h111);
        chk("first_gnt0_m1_ack", m1_if.ack, 0);
        s_if.ack = 1'b1; s_if.dat_s = D_ONE;
        settle();
        chk("first_m0_ack", m0_if.ack, 1);
        chk("first_m0_dat_s", m0_if.dat_s, D_ONE);
        chk("first_m1_dat_s", m1_if.dat_s, 0);
        nxt();
        m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
        m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
        s_if.ack = 1'b0;
        settle();
        chk("gap1_s_stb", s_if.stb, 0);
        chk("gap1_s_cyc", s_if.cyc, 0);
        nxt();
        chk("no_req_idle_stb", s_if.stb, 0);

        // 2. m1 read alone
        m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.we = 1'b0; m1_if.adr = 12'h0A5;
        settle();
        chk("m1rd_latency_stb", s_if.stb, 0);
        nxt();
        chk("m1rd_stb", s_if.stb, 1);
        chk("m1rd_we", s_if.we, 0);
        chk("m1rd_adr", s_if.adr, 12'h0A5);
        s_if.ack = 1'b1; s_if.dat_s = D_BEEF;
        settle();
        chk("m1rd_m1_ack", m1_if.ack, 1);
        chk("m1rd_m1_dat_s", m1_if.dat_s, D_BEEF);
        chk("m1rd_m0_ack", m0_if.ack, 0);
        chk("m1rd_m0_dat_s", m0_if.dat_s, 0);
        nxt();
        m1_if.cyc = 1'b0; m1_if.stb = 1'b0; s_if.ack = 1'b0;
        settle();
        chk("m1rd_after_stb", s_if.stb, 0);

        // 3. both request continuously, memory acks every cycle
        m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 12'h100;
        m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 12'h200;
        s_if.ack = 1'b1;
        settle();
        chk("rr_idle_m0_ack", m0_if.ack, 0);
        for (int g = 0; g < 4; g++) begin
            nxt();
            chk("rr_gnt_cyc", s_if.cyc, 1);
            chk("rr_gnt_adr", s_if.adr, (g % 2 == 1) ? 12'h200 : 12'h100);
            if (g < 3) begin
                nxt();
                chk("rr_gap_cyc", s_if.cyc, 0);
                chk("rr_gap_m1_ack", m1_if.ack, 0);
            end
        end
        m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
        m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
        s_if.ack = 1'b0;
        nxt();

        // 4. m0 write, fields forwarded live, then stray ack while idle
        m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b1;
        m0_if.adr = 12'h3C3; m0_if.sel = 16'hFFFF; m0_if.dat_m = D_WR;
        nxt();
        chk("m0wr_we", s_if.we, 1);
        chk("m0wr_dat_m", s_if.dat_m, D_WR);
        chk("m0wr_sel", s_if.sel, 16'hFFFF);
        chk("m0wr_adr", s_if.adr, 12'h3C3);
        nxt();
        chk("m0wr_hold_stb", s_if.stb, 1);
        m0_if.sel = 16'h00FF;
        settle();
        chk("m0wr_live_sel", s_if.sel, 16'h00FF);
        s_if.ack = 1'b1;
        settle();
        chk("m0wr_m0_ack", m0_if.ack, 1);
        nxt();
        m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.we = 1'b0;
        settle();
        chk("stray_m0_ack", m0_if.ack, 0);
        chk("stray_m1_ack", m1_if.ack, 0);
        chk("stray_s_stb", s_if.stb, 0);

        // 5. m1 granted then aborts, pending m0 follows
        s_if.ack = 1'b0;
        m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 12'h0F0;
        m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 12'h077;
        nxt();
        chk("abort_gnt1_adr", s_if.adr, 12'h077);
        m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
        settle();
        chk("abort_s_cyc", s_if.cyc, 0);
        chk("abort_m0_ack", m0_if.ack, 0);
        nxt();
        chk("abort_idle_stb", s_if.stb, 0);
        nxt();
        chk("abort_gnt0_stb", s_if.stb, 1);
        chk("abort_gnt0_adr", s_if.adr, 12'h0F0);

        // 6. async reset mid-GNT0, between clock edges
        settle();
        rst_n = 1'b0;
        #1;
        chk("async_rst_stb", s_if.stb, 0);
        chk("async_rst_cyc", s_if.cyc, 0);
        m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 12'h077;
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_release_idle_stb", s_if.stb, 0);
        nxt();
        chk("rst_release_gnt0_adr", s_if.adr, 12'h0F0);
        chk("rst_release_m1_ack", m1_if.ack, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
